// File: rtl/branch_outcome_tracker.sv
// -----------------------------------------------------------------------------
// branch_outcome_tracker
//
// Client side of a 2-bit branch predictor port. Fetch lookups are turned into
// predictor requests; each returned prediction is queued in order. Each
// resolved outcome from execute is matched against the oldest queued
// prediction, drives the predictor update and flags a mispredict. Request and
// result toward the predictor are never asserted in the same cycle.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   fetch_valid / fetch_ready   lookup handshake from fetch
//   fetch_pred_valid/fetch_pred one-cycle prediction pulse back to fetch
//   resolve_valid/resolve_taken resolved outcome of the oldest branch
//   resolve_ready               resolve handshake
//   mispredict                  one-cycle pulse, outcome != queued prediction
//   flush                       discard every queued / in-flight lookup
//   pred_request                predictor: request a prediction
//   pred_result / pred_taken    predictor: apply update with direction
//   prediction                  predictor answer, valid cycle after request
//   fifo_count                  number of queued predictions
//   stat_resolved/stat_mispred  saturating statistics
// -----------------------------------------------------------------------------
module branch_outcome_tracker #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       fetch_valid,
   output logic                       fetch_ready,
   output logic                       fetch_pred_valid,
   output logic                       fetch_pred,
   input  logic                       resolve_valid,
   input  logic                       resolve_taken,
   output logic                       resolve_ready,
   output logic                       mispredict,
   input  logic                       flush,
   output logic                       pred_request,
   output logic                       pred_result,
   output logic                       pred_taken,
   input  logic                       prediction,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic [CNT_W-1:0]           stat_resolved,
   output logic [CNT_W-1:0]           stat_mispred
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_WID = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_CAP,
      S_UPD
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic               r_fifo [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_WID-1:0] r_count;

   // Flush seen while in REQ: the lookup is abandoned when CAP completes.
   logic               r_flushed;

   logic               r_fetch_pred_valid;
   logic               r_fetch_pred;
   logic               r_mispredict;
   logic               r_pred_request;
   logic               r_pred_result;
   logic               r_pred_taken;
   logic [CNT_W-1:0]   r_stat_resolved;
   logic [CNT_W-1:0]   r_stat_mispred;

   logic               w_idle;
   logic               w_nonempty;
   logic               w_full;
   logic               w_fetch_acc;
   logic               w_res_acc;
   logic               w_push;
   logic               w_head;
   logic               w_mis;

   assign w_idle     = (r_state == S_IDLE);
   assign w_nonempty = (r_count != '0);
   assign w_full     = (r_count == CNT_WID'(DEPTH));
   assign w_head     = r_fifo[r_rd_ptr];
   assign w_mis      = (w_head != resolve_taken);

   // Handshake readies are decoded from registered state and gated by the
   // current flush / reset so nothing is accepted on a discarding edge.
   // A pending resolve blocks fetch, which keeps the two accepts exclusive.
   assign resolve_ready = rst_n & w_idle & w_nonempty & ~flush;
   assign fetch_ready   = rst_n & w_idle & ~w_full & ~flush &
                          ~(resolve_valid & w_nonempty);

   assign w_res_acc   = resolve_valid & resolve_ready;
   assign w_fetch_acc = fetch_valid & fetch_ready;
   assign w_push      = (r_state == S_CAP) & ~flush & ~r_flushed & ~w_full;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_res_acc)
               w_state_nxt = S_UPD;
            else if (w_fetch_acc)
               w_state_nxt = S_REQ;
         end
         S_REQ:   w_state_nxt = S_CAP;
         S_CAP:   w_state_nxt = S_IDLE;
         S_UPD:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr           <= '0;
         r_rd_ptr           <= '0;
         r_count            <= '0;
         r_flushed          <= 1'b0;
         r_fetch_pred_valid <= 1'b0;
         r_fetch_pred       <= 1'b0;
         r_mispredict       <= 1'b0;
         r_pred_request     <= 1'b0;
         r_pred_result      <= 1'b0;
         r_pred_taken       <= 1'b0;
         r_stat_resolved    <= '0;
         r_stat_mispred     <= '0;
      end else begin
         r_pred_request     <= w_fetch_acc;
         r_pred_result      <= w_res_acc;
         r_pred_taken       <= w_res_acc & resolve_taken;
         r_mispredict       <= w_res_acc & w_mis;
         r_fetch_pred_valid <= w_push;
         r_fetch_pred       <= w_push & prediction;
         r_flushed          <= (r_state == S_REQ) & flush;

         // Push (CAP) and pop (IDLE accept) occur in different states, so
         // at most one of them is active on any edge; flush overrides both.
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else if (w_push) begin
            r_fifo[r_wr_ptr] <= prediction;
            r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            r_count          <= r_count + CNT_WID'(1);
         end else if (w_res_acc) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count  <= r_count - CNT_WID'(1);
         end

         if (w_res_acc) begin
            if (r_stat_resolved != '1)
               r_stat_resolved <= r_stat_resolved + CNT_W'(1);
            if (w_mis && (r_stat_mispred != '1))
               r_stat_mispred <= r_stat_mispred + CNT_W'(1);
         end
      end
   end

   assign fetch_pred_valid = r_fetch_pred_valid;
   assign fetch_pred       = r_fetch_pred;
   assign mispredict       = r_mispredict;
   assign pred_request     = r_pred_request;
   assign pred_result      = r_pred_result;
   assign pred_taken       = r_pred_taken;
   assign fifo_count       = r_count;
   assign stat_resolved    = r_stat_resolved;
   assign stat_mispred     = r_stat_mispred;

   a_req_res_excl : assert property (@(posedge clk) disable iff (!rst_n)
                                     !(r_pred_request && r_pred_result));

endmodule

// File: tb/tb_branch_outcome_tracker.sv
module tb_branch_outcome_tracker;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT 1: DEPTH=4, CNT_W=16 with predictor model ----------
   logic        rst_n, fetch_valid, resolve_valid, resolve_taken, flush;
   logic        fetch_ready, fetch_pred_valid, fetch_pred, resolve_ready;
   logic        mispredict, pred_request, pred_result, pred_taken;
   logic        prediction = 1'b0;
   logic [2:0]  fifo_count;
   logic [15:0] stat_resolved, stat_mispred;

   branch_outcome_tracker #(.DEPTH(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .fetch_pred_valid(fetch_pred_valid), .fetch_pred(fetch_pred),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .resolve_ready(resolve_ready), .mispredict(mispredict),
      .flush(flush),
      .pred_request(pred_request), .pred_result(pred_result),
      .pred_taken(pred_taken), .prediction(prediction),
      .fifo_count(fifo_count),
      .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
   );

   // 2-bit saturating predictor; bench can load its counter directly.
   logic [1:0] pc = 2'b00;
   logic       pc_wr = 1'b0;
   logic [1:0] pc_wval = 2'b00;
   always @(posedge clk) begin
      if (pc_wr)
         pc <= pc_wval;
      else if (pred_result)
         pc <= pred_taken ? ((pc == 2'd3) ? 2'd3 : pc + 2'd1)
                          : ((pc == 2'd0) ? 2'd0 : pc - 2'd1);
      if (pred_request)
         prediction <= pc[1];
   end

   // ---------------- DUT 2: CNT_W=2, predictor answers "taken" ---------------
   logic        rst2, f2_valid, r2_valid, r2_taken;
   logic        f2_ready, fp2_valid, fp2, r2_ready, mis2, req2, res2, tk2;
   logic        pred2 = 1'b1;
   logic        flush2 = 1'b0;
   logic [2:0]  cnt2;
   logic [1:0]  sres2, smis2;

   branch_outcome_tracker #(.DEPTH(4), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst2),
      .fetch_valid(f2_valid), .fetch_ready(f2_ready),
      .fetch_pred_valid(fp2_valid), .fetch_pred(fp2),
      .resolve_valid(r2_valid), .resolve_taken(r2_taken),
      .resolve_ready(r2_ready), .mispredict(mis2),
      .flush(flush2),
      .pred_request(req2), .pred_result(res2),
      .pred_taken(tk2), .prediction(pred2),
      .fifo_count(cnt2),
      .stat_resolved(sres2), .stat_mispred(smis2)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int overlap = 0;

   always @(negedge clk) begin
      if ((pred_request === 1'b1) && (pred_result === 1'b1)) overlap++;
      if ((req2 === 1'b1) && (res2 === 1'b1)) overlap++;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_pc(input logic [1:0] v);
      pc_wr = 1'b1;
      pc_wval = v;
      step();
      pc_wr = 1'b0;
   endtask

   // Starts in IDLE; ends in the cycle carrying the fetch_pred_valid pulse.
   task automatic do_lookup(input string tag, input logic exp_pred);
      fetch_valid = 1'b1;
      #1 check({tag, "_ready"}, fetch_ready, 1'b1);
      step();
      fetch_valid = 1'b0;
      step();
      step();
      check({tag, "_pv"}, fetch_pred_valid, 1'b1);
      check({tag, "_pred"}, fetch_pred, exp_pred);
   endtask

   // Starts in IDLE; ends back in IDLE after the UPD cycle.
   task automatic do_resolve(input string tag, input logic taken,
                             input logic exp_mis);
      resolve_valid = 1'b1;
      resolve_taken = taken;
      #1 check({tag, "_rready"}, resolve_ready, 1'b1);
      step();
      resolve_valid = 1'b0;
      check({tag, "_result"}, pred_result, 1'b1);
      check({tag, "_taken"}, pred_taken, taken);
      check({tag, "_mis"}, mispredict, exp_mis);
      step();
   endtask

   initial begin
      rst_n = 1'b0; fetch_valid = 1'b0; resolve_valid = 1'b0;
      resolve_taken = 1'b0; flush = 1'b0;
      rst2 = 1'b0; f2_valid = 1'b0; r2_valid = 1'b0; r2_taken = 1'b0;
      pc_wr = 1'b1; pc_wval = 2'd3;
      repeat (3) step();
      pc_wr = 1'b0;

      check("rst_count", fifo_count, 0);
      check("rst_req", pred_request, 0);
      check("rst_pv", fetch_pred_valid, 0);
      check("rst_stat", stat_resolved, 0);
      check("rst_fready", fetch_ready, 0);

      // 1: lookup with predictor counter = 11
      rst_n = 1'b1;
      fetch_valid = 1'b1;
      #1 check("t1_fready", fetch_ready, 1);
      step();
      fetch_valid = 1'b0;
      check("t1_req_c1", pred_request, 1);
      check("t1_fready_busy", fetch_ready, 0);
      step();
      check("t1_req_c2", pred_request, 0);
      check("t1_pv_c2", fetch_pred_valid, 0);
      step();
      check("t1_pv_c3", fetch_pred_valid, 1);
      check("t1_pred_c3", fetch_pred, 1);
      check("t1_count", fifo_count, 1);
      step();
      check("t1_pv_c4", fetch_pred_valid, 0);

      // 2: resolve not-taken against predicted taken
      resolve_valid = 1'b1;
      resolve_taken = 1'b0;
      #1 check("t2_rready", resolve_ready, 1);
      step();
      resolve_valid = 1'b0;
      check("t2_result", pred_result, 1);
      check("t2_taken", pred_taken, 0);
      check("t2_mis", mispredict, 1);
      check("t2_sres", stat_resolved, 1);
      check("t2_smis", stat_mispred, 1);
      check("t2_count", fifo_count, 0);
      step();
      check("t2_mis_pulse", mispredict, 0);
      check("t2_result_pulse", pred_result, 0);

      // 3: fill to DEPTH with predictions 1,1,0,0 then resolve 1,0,0,1
      set_pc(2'd3);
      do_lookup("t3_l0", 1'b1);
      do_lookup("t3_l1", 1'b1);
      set_pc(2'd0);
      do_lookup("t3_l2", 1'b0);
      do_lookup("t3_l3", 1'b0);
      check("t3_full_count", fifo_count, 4);
      fetch_valid = 1'b1;
      #1 check("t3_full_fready", fetch_ready, 0);
      fetch_valid = 1'b0;
      do_resolve("t3_r0", 1'b1, 1'b0);
      do_resolve("t3_r1", 1'b0, 1'b1);
      do_resolve("t3_r2", 1'b0, 1'b0);
      do_resolve("t3_r3", 1'b1, 1'b1);
      check("t3_sres", stat_resolved, 5);
      check("t3_smis", stat_mispred, 3);
      check("t3_count", fifo_count, 0);

      // 4: counter now 01 -> predicts 0; fetch and resolve together
      do_lookup("t4_l", 1'b0);
      step();
      fetch_valid = 1'b1;
      resolve_valid = 1'b1;
      resolve_taken = 1'b0;
      #1 check("t4_rready", resolve_ready, 1);
      check("t4_fready_blocked", fetch_ready, 0);
      step();
      resolve_valid = 1'b0;
      check("t4_result", pred_result, 1);
      check("t4_noreq", pred_request, 0);
      check("t4_mis", mispredict, 0);
      step();
      #1 check("t4_fready_next", fetch_ready, 1);
      step();
      fetch_valid = 1'b0;
      check("t4_req", pred_request, 1);
      step();
      step();
      check("t4_pv", fetch_pred_valid, 1);
      check("t4_pred", fetch_pred, 0);
      check("t4_count", fifo_count, 1);
      check("t4_sres", stat_resolved, 6);

      // 5: flush during CAP with 2 queued
      step();
      do_lookup("t5_l", 1'b0);
      check("t5_count2", fifo_count, 2);
      step();
      fetch_valid = 1'b1;
      #1 step();
      fetch_valid = 1'b0;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t5_no_pv", fetch_pred_valid, 0);
      check("t5_count0", fifo_count, 0);
      #1 check("t5_idle", fetch_ready, 1);
      resolve_valid = 1'b1;
      #1 check("t5_rready", resolve_ready, 0);
      step();
      resolve_valid = 1'b0;
      check("t5_no_result", pred_result, 0);
      check("t5_sres", stat_resolved, 6);

      // 6: CNT_W=2 saturation, then reset during UPD
      rst2 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         f2_valid = 1'b1;
         #1 step();
         f2_valid = 1'b0;
         step();
         step();
         r2_valid = 1'b1;
         r2_taken = 1'b0;
         #1 step();
         r2_valid = 1'b0;
         check("t6_mis", mis2, 1);
         if (i == 4) begin
            check("t6_smis_sat", smis2, 3);
            check("t6_sres_sat", sres2, 3);
         end
         if (i < 5) step();
      end
      check("t6_in_upd", res2, 1);
      rst2 = 1'b0;
      step();
      check("t6_rst_result", res2, 0);
      check("t6_rst_mis", mis2, 0);
      check("t6_rst_smis", smis2, 0);
      check("t6_rst_sres", sres2, 0);
      check("t6_rst_cnt", cnt2, 0);
      check("t6_rst_fready", f2_ready, 0);
      check("t6_rst_pv", fp2_valid, 0);

      step();
      check("req_res_overlap", overlap, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
